// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the memory/IO responder: bus widths,
// the IO window decode values and the address-region decode helper.
package mem_io_responder_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 32;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // IO window select on mem_a[17:16] and port offsets on mem_a[2:0]
  localparam logic [1:0] IO_SEL       = 2'b11;
  localparam logic [2:0] IO_PORT_UART = 3'd0;
  localparam logic [2:0] IO_PORT_CLK  = 3'd4;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_NONE,
    REGION_IO
  } region_e;

  // Map mem_a[17:16] to the region it selects
  function automatic region_e decode_region(input logic [1:0] sel);
    if (sel == IO_SEL)     return REGION_IO;
    else if (sel == 2'b10) return REGION_NONE;
    else                   return REGION_RAM;
  endfunction

endpackage

// File: rtl/mem_io_responder_io_tx_fifo.sv
// Synchronous UART TX FIFO: push/pop, occupancy count and a registered
// near-full flag that leaves room for one IO write already in flight.
module io_tx_fifo #(
  parameter int DEPTH       = 8,
  parameter int FULL_MARGIN = 2,
  parameter int W           = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop_ready,
  output logic [W-1:0]               data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       near_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             pop;
  logic             push_ok;

  assign valid = (count != '0);
  assign data  = mem[rd_ptr];

  // Accept/pop decisions and next occupancy
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    count_next = count;
    pop        = valid && pop_ready;
    // A push into a full FIFO only lands if a pop frees a slot this cycle.
    push_ok    = push && ((count != CNT_W'(DEPTH)) || pop);
    case ({push_ok, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage write; contents are don't-care until pushed
  // NOTE: memory arrays are not reset; pointers and count alone define validity.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, count and near-full flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      near_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      near_full <= (DEPTH - int'(count_next)) <= FULL_MARGIN;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Slave end of the CPU byte-wide memory bus: 128KB read-first RAM with a
// registered read, plus an IO window with UART TX FIFO, UART RX byte,
// cycle counter and program-stop flag.
// Optional feature: define CLK_COUNTER_EN to build the 32-bit cycle counter
// (coherent snapshot read at 0x30004..7); otherwise those reads return 0x00.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W    = 17,
  parameter int TX_FIFO_DEPTH = 8,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop
);

  region_e                 region;
  logic [2:0]              io_port;
  logic                    io_rd;
  logic                    io_wr;
  byte_t                   io_rdata;
  logic                    rx_take;
  logic                    fifo_push;
  byte_t                   fifo_push_data;
  logic [$clog2(TX_FIFO_DEPTH):0] tx_count;

  byte_t                   ram [2**RAM_ADDR_W];
  byte_t                   ram_q;
  byte_t                   io_q;
  logic                    ram_sel_q;

`ifdef CLK_COUNTER_EN
  logic [31:0]             cycle_cnt;
  logic [31:0]             cnt_snap;
`endif

  assign region  = decode_region(mem_a[17:16]);
  assign io_port = mem_a[2:0];
  assign io_rd   = (region == REGION_IO) && !mem_wr;
  assign io_wr   = (region == REGION_IO) &&  mem_wr;

  // Read data comes from the RAM register or the IO register chosen last cycle
  assign mem_rdata = ram_sel_q ? ram_q : io_q;

  // IO read mux, RX consume strobe and TX push request
  always_comb begin
    io_rdata       = '0;
    rx_take        = 1'b0;
    fifo_push      = 1'b0;
    fifo_push_data = mem_wdata;
    if (io_rd) begin
      case (io_port)
        IO_PORT_UART: begin
          io_rdata = rx_valid ? rx_data : '0;
          rx_take  = rx_valid;
        end
`ifdef CLK_COUNTER_EN
        // Byte 0 comes live from the counter; the snapshot serves bytes 1..3.
        IO_PORT_CLK: io_rdata = cycle_cnt[7:0];
        3'd5:        io_rdata = cnt_snap[15:8];
        3'd6:        io_rdata = cnt_snap[23:16];
        3'd7:        io_rdata = cnt_snap[31:24];
`endif
        default:     io_rdata = '0;
      endcase
    end
    if (io_wr) begin
      if (io_port == IO_PORT_UART && mem_wdata != '0) begin
        fifo_push = 1'b1;
      end else if (io_port == IO_PORT_CLK) begin
        // Program stop also terminates the TX string with a '\0'.
        fifo_push      = 1'b1;
        fifo_push_data = '0;
      end
    end
  end

  // RAM: read-first port, write only when the RAM region is addressed
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments make the read capture the pre-write byte.
    ram_q <= ram[mem_a[RAM_ADDR_W-1:0]];
    if (mem_wr && region == REGION_RAM) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_wdata;
  end

  // Read-source select, IO read data, RX strobe and sticky stop flag
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ram_sel_q    <= 1'b0;
      io_q         <= '0;
      rx_ready     <= 1'b0;
      program_stop <= 1'b0;
    end else begin
      ram_sel_q <= (region == REGION_RAM);
      io_q      <= io_rdata;
      rx_ready  <= rx_take;
      if (io_wr && io_port == IO_PORT_CLK) program_stop <= 1'b1;
    end
  end

`ifdef CLK_COUNTER_EN
  // Free-running cycle counter and snapshot taken on a byte-0 read
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cycle_cnt <= '0;
      cnt_snap  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (io_rd && io_port == IO_PORT_CLK) cnt_snap <= cycle_cnt;
    end
  end
`endif

  io_tx_fifo #(
    .DEPTH       (TX_FIFO_DEPTH),
    .FULL_MARGIN (FULL_MARGIN),
    .W           (BYTE_W)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop_ready (tx_ready),
    .data      (tx_data),
    .valid     (tx_valid),
    .count     (tx_count),
    .near_full (io_buffer_full)
  );

  // Address bits outside the decode and the FIFO count are intentionally unused
  logic unused_ok;
  assign unused_ok = ^{mem_a[31:18], mem_a[15:3], tx_count};

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM latency and
// read-first behaviour, unmapped/IO decode, TX FIFO fill/drain/full,
// RX handshake, async reset and (with CLK_COUNTER_EN) the counter snapshot.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] IDLE_A = 32'h0002_0000;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .program_stop   (program_stop)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] wd);
    mem_a     = a;
    mem_wr    = wr;
    mem_wdata = wd;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_b0;
    logic [7:0] exp_b1;
    rst_in   = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    drive(IDLE_A, 1'b0, 8'h00);
    #3 rst_in = 1'b1;
    step();
    step();
    check("rst_rdata",  32'(mem_rdata), 32'h00);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h0);
    check("rst_stop",   32'(program_stop), 32'h0);
    check("rst_full",   32'(io_buffer_full), 32'h0);
    rst_in = 1'b0;

    // RAM write then read: data appears one cycle after the read
    drive(32'h40, 1'b1, 8'h11);  step();
    drive(32'h100, 1'b1, 8'hA5); step();
    drive(32'h100, 1'b0, 8'h00); step();
    check("ram_read", 32'(mem_rdata), 32'hA5);
    drive(IDLE_A, 1'b0, 8'h00);  step();
    check("ram_next_idle", 32'(mem_rdata), 32'h00);

    // Same-cycle write/read returns the old byte
    drive(32'h40, 1'b1, 8'h3C);  step();
    check("ram_read_first", 32'(mem_rdata), 32'h11);
    drive(32'h40, 1'b0, 8'h00);  step();
    check("ram_after_write", 32'(mem_rdata), 32'h3C);

    // Unmapped region and unused IO offset
    drive(32'h20040, 1'b1, 8'h99); step();
    drive(32'h20040, 1'b0, 8'h00); step();
    check("unmapped_read", 32'(mem_rdata), 32'h00);
    drive(32'h40, 1'b0, 8'h00);    step();
    check("unmapped_no_alias", 32'(mem_rdata), 32'h3C);
    drive(32'h30002, 1'b0, 8'h00); step();
    check("io_other_read", 32'(mem_rdata), 32'h00);

    // TX FIFO: six pushes with tx_ready low
    for (int i = 0; i < 6; i++) begin
      drive(32'h30000, 1'b1, 8'(8'h41 + i));
      step();
      check("fifo_full_flag", 32'(io_buffer_full), (i == 5) ? 32'h1 : 32'h0);
    end
    check("fifo_tx_valid", 32'(tx_valid), 32'h1);
    check("fifo_head", 32'(tx_data), 32'h41);
    check("fifo_count6", 32'(dut.u_tx_fifo.count), 32'd6);
    drive(32'h30000, 1'b1, 8'h00); step();
    check("fifo_zero_ignored", 32'(dut.u_tx_fifo.count), 32'd6);
    drive(32'h30004, 1'b1, 8'h55); step();
    check("fifo_stop_push", 32'(dut.u_tx_fifo.count), 32'd7);
    check("stop_set", 32'(program_stop), 32'h1);

    // Drain: 0x41..0x46 then the terminating 0x00
    drive(IDLE_A, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("drain_data", 32'(tx_data), (i == 6) ? 32'h00 : 32'(8'h41 + i));
      step();
    end
    tx_ready = 1'b0;
    check("drain_empty", 32'(tx_valid), 32'h0);
    check("drain_full_clr", 32'(io_buffer_full), 32'h0);
    check("stop_sticky", 32'(program_stop), 32'h1);

    // Full boundary: push with pop accepted, push without pop dropped
    for (int i = 0; i < 8; i++) begin
      drive(32'h30000, 1'b1, 8'(i + 1));
      step();
    end
    check("full_count8", 32'(dut.u_tx_fifo.count), 32'd8);
    check("full_flag", 32'(io_buffer_full), 32'h1);
    drive(32'h30000, 1'b1, 8'h09);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check("full_push_pop_count", 32'(dut.u_tx_fifo.count), 32'd8);
    check("full_push_pop_head", 32'(tx_data), 32'h02);
    drive(32'h30000, 1'b1, 8'h0A); step();
    check("full_push_dropped", 32'(dut.u_tx_fifo.count), 32'd8);
    drive(IDLE_A, 1'b0, 8'h00);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("full_drain_data", 32'(tx_data), 32'(i + 2));
      step();
    end
    tx_ready = 1'b0;
    check("full_drain_empty", 32'(tx_valid), 32'h0);

    // RX read with and without a byte available
    rx_valid = 1'b1;
    rx_data  = 8'h7E;
    drive(32'h30000, 1'b0, 8'h00); step();
    check("rx_data", 32'(mem_rdata), 32'h7E);
    check("rx_ready_pulse", 32'(rx_ready), 32'h1);
    drive(32'h100, 1'b0, 8'h00);   step();
    check("rx_ready_one_cycle", 32'(rx_ready), 32'h0);
    check("ram_after_rx", 32'(mem_rdata), 32'hA5);
    rx_valid = 1'b0;
    drive(32'h30000, 1'b0, 8'h00); step();
    check("rx_empty_data", 32'(mem_rdata), 32'h00);
    check("rx_empty_no_pulse", 32'(rx_ready), 32'h0);

    // Reset mid-stream
    drive(32'h30000, 1'b1, 8'h31); step();
    drive(32'h30000, 1'b1, 8'h32); step();
    drive(32'h30004, 1'b1, 8'h00); step();
    drive(32'h100, 1'b0, 8'h00);   step();
    check("pre_rst_rdata", 32'(mem_rdata), 32'hA5);
    check("pre_rst_stop", 32'(program_stop), 32'h1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_rdata", 32'(mem_rdata), 32'h00);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("mid_rst_stop", 32'(program_stop), 32'h0);
    check("mid_rst_full", 32'(io_buffer_full), 32'h0);
    step();
    rst_in = 1'b0;
    drive(32'h100, 1'b0, 8'h00); step();
    check("ram_retained_100", 32'(mem_rdata), 32'hA5);
    drive(32'h40, 1'b0, 8'h00);  step();
    check("ram_retained_40", 32'(mem_rdata), 32'h3C);

    // Counter: 300 edges after reset release, then read bytes 0 and 1
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    drive(IDLE_A, 1'b0, 8'h00);
    repeat (300) step();
`ifdef CLK_COUNTER_EN
    exp_b0 = 8'h2C;
    exp_b1 = 8'h01;
`else
    exp_b0 = 8'h00;
    exp_b1 = 8'h00;
`endif
    drive(32'h30004, 1'b0, 8'h00); step();
    check("cnt_byte0", 32'(mem_rdata), 32'(exp_b0));
    drive(32'h30005, 1'b0, 8'h00); step();
    check("cnt_byte1", 32'(mem_rdata), 32'(exp_b1));
    drive(32'h30007, 1'b0, 8'h00); step();
    check("cnt_byte3", 32'(mem_rdata), 32'h00);
    drive(IDLE_A, 1'b0, 8'h00);    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
